// File: rtl/ms_pkg.sv
// Shared types for the ms_if command master: command record, master FSM states
// and default bus widths.
package ms_pkg;

  localparam int MS_ADDR_W = 4;
  localparam int MS_DATA_W = 8;

  typedef struct packed {
    logic [MS_ADDR_W-1:0] addr;
    logic [MS_DATA_W-1:0] data;
  } ms_cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    DROP
  } ms_mst_state_e;

endpackage

// File: rtl/ms_cmd_fifo.sv
// Synchronous command FIFO. Pointers carry one extra wrap bit so that full and
// empty are distinguishable. The entry behind the head is exposed for back-to-back issue.
module ms_cmd_fifo
  import ms_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = ms_cmd_t
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  T                       data_i,
  output T                       head_o,
  output T                       second_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int AW = $clog2(DEPTH);

  T             mem_q [DEPTH];
  logic [AW:0]  wrPtr_q;
  logic [AW:0]  rdPtr_q;
  logic [AW-1:0] rdNext;
  logic         doPush;
  logic         doPop;

  assign full_o  = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
  assign empty_o = (wrPtr_q == rdPtr_q);
  assign level_o = wrPtr_q - rdPtr_q;
  assign doPush  = push_i && !full_o;
  assign doPop   = pop_i && !empty_o;
  assign rdNext  = rdPtr_q[AW-1:0] + 1'b1;

  assign head_o   = mem_q[rdPtr_q[AW-1:0]];
  assign second_o = mem_q[rdNext];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
      if (doPop)  rdPtr_q <= rdPtr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/ms_cmd_master.sv
// Command master for the ms_if register slave: queues write commands, issues
// them with sready back-pressure, and drops a command stalled past TIMEOUT.
module ms_cmd_master
  import ms_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int ADDR_W  = MS_ADDR_W,
  parameter int DATA_W  = MS_DATA_W,
  parameter int TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [ADDR_W-1:0]      cmd_addr,
  input  logic [DATA_W-1:0]      cmd_data,
  output logic                   m_valid,
  output logic [ADDR_W-1:0]      m_addr,
  output logic [DATA_W-1:0]      m_data,
  input  logic                   m_sready,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level,
  output logic                   err
);

  localparam int LW   = $clog2(DEPTH) + 1;
  localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } cmd_t;

  ms_mst_state_e     state_q, state_d;
  logic              mValid_q, mValid_d;
  logic [ADDR_W-1:0] mAddr_q, mAddr_d;
  logic [DATA_W-1:0] mData_q, mData_d;
  logic              err_q, err_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              pop;
  logic              full;
  logic              empty;
  logic              wdHit;
  logic              moreQueued;
  cmd_t              head;
  cmd_t              second;
  cmd_t              pushCmd;

  assign pushCmd = '{addr: cmd_addr, data: cmd_data};

  ms_cmd_fifo #(
    .DEPTH (DEPTH),
    .T     (cmd_t)
  ) uFifo (
    .clk      (clk),
    .rst      (rst),
    .push_i   (cmd_valid),
    .pop_i    (pop),
    .data_i   (pushCmd),
    .head_o   (head),
    .second_o (second),
    .full_o   (full),
    .empty_o  (empty),
    .level_o  (level)
  );

  // The presented command stays in the FIFO until it retires, so a follow-on
  // command exists only when at least two entries are queued.
  assign moreQueued = (level > LW'(1));
  assign wdHit      = (TIMEOUT != 0) && (wd_q == WD_MAX);

  always_comb begin
    state_d  = state_q;
    mValid_d = mValid_q;
    mAddr_d  = mAddr_q;
    mData_d  = mData_q;
    wd_d     = wd_q;
    err_d    = 1'b0;
    pop      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          state_d  = SEND;
          mValid_d = 1'b1;
          mAddr_d  = head.addr;
          mData_d  = head.data;
          wd_d     = '0;
        end
      end
      SEND: begin
        if (m_sready) begin
          pop = 1'b1;
          if (moreQueued) begin
            mAddr_d = second.addr;
            mData_d = second.data;
            wd_d    = '0;
          end else begin
            state_d  = IDLE;
            mValid_d = 1'b0;
            mAddr_d  = '0;
            mData_d  = '0;
          end
        end else if (wdHit) begin
          state_d  = DROP;
          mValid_d = 1'b0;
          mAddr_d  = '0;
          mData_d  = '0;
          err_d    = 1'b1;
        end else if (wd_q != WD_MAX) begin
          wd_d = wd_q + 1'b1;
        end
      end
      DROP: begin
        pop = 1'b1;
        if (moreQueued) begin
          state_d  = SEND;
          mValid_d = 1'b1;
          mAddr_d  = second.addr;
          mData_d  = second.data;
          wd_d     = '0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      mValid_q <= 1'b0;
      mAddr_q  <= '0;
      mData_q  <= '0;
      err_q    <= 1'b0;
      wd_q     <= '0;
    end else begin
      state_q  <= state_d;
      mValid_q <= mValid_d;
      mAddr_q  <= mAddr_d;
      mData_q  <= mData_d;
      err_q    <= err_d;
      wd_q     <= wd_d;
    end
  end

  assign cmd_ready = !full;
  assign m_valid   = mValid_q;
  assign m_addr    = mAddr_q;
  assign m_data    = mData_q;
  assign err       = err_q;
  assign busy      = (level != '0) || mValid_q;

endmodule
